zmc2_dot_seq: RTL

- Sequencer for the ZMC2 sprite dot shifter.
- Accepts a sprite-line render command: start X, H-flip and tile count.
- Fetches 32-bit character words from the fetch unit over a req/ack handshake and drives the shifter's CR/LOAD/H/EVEN inputs.
- Emits line-buffer write strobes and X addresses aligned to the shifter's GAD/GBD pixel pairs.
- Sits between the LSPC sprite fetch logic and the zmc2 dot shifter.

---
 rtl/neo_video_pkg.sv | 24 ++
 rtl/zmc2_dot_seq_word_buf.sv | 51 +++++
 rtl/zmc2_dot_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/neo_video_pkg.sv
// Shared types and constants for the NEO video sprite pipeline.
// Build option: ZMC2_SEQ_CLIP_EN (visible-width write clipping in zmc2_dot_seq).
package neo_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SHIFT0,
    SHIFT1,
    SHIFT2,
    SHIFT3,
    FLUSH
  } seq_state_t;

  localparam int SCREEN_W       = 320;
  localparam int PAIRS_PER_WORD = 4;
  localparam int WORDS_PER_TILE = 2;

  function automatic logic is_shift(seq_state_t s);
    return (s == SHIFT0) || (s == SHIFT1) ||
           (s == SHIFT2) || (s == SHIFT3);
  endfunction

endpackage

// File: rtl/zmc2_dot_seq_word_buf.sv
// One-deep req/ack capture buffer for ZMC2 character words.
// Issues half-tile requests in alternating order until the command's words are fetched.
module zmc2_word_buf
  import neo_video_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flip,
  input  logic [CW-1:0] words,
  input  logic          ack,
  input  logic [31:0]   din,
  input  logic          drain,
  output logic          full,
  output logic [31:0]   data,
  output logic          req,
  output logic          wsel
);

  logic [CW-1:0] pending;
  logic [31:0]   buf_q;
  logic          take;

  assign req  = !full && (pending != '0);
  assign take = req && ack;
  // Forward a word arriving this cycle so the shifter loads it next cycle.
  assign data = take ? din : buf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      buf_q   <= '0;
      pending <= '0;
      wsel    <= 1'b0;
    end else if (start) begin
      full    <= 1'b0;
      pending <= words;
      wsel    <= flip;
    end else begin
      full <= take || (full && !drain);
      if (take) begin
        buf_q   <= din;
        pending <= pending - CW'(1);
        wsel    <= ~wsel;
      end
    end
  end

endmodule

// File: rtl/zmc2_dot_seq.sv
// ZMC2 dot shifter sequencer: word fetch, CR/LOAD/H/EVEN drive, pair write strobes.
// Build option: ZMC2_SEQ_CLIP_EN suppresses writes for pairs at X >= SCREEN_W.
module zmc2_dot_seq
  import neo_video_pkg::*;
#(
  parameter int XW = 9,
  parameter int TW = 5
) (
  input  logic          CLK_12M,
  input  logic          RESET,
  input  logic          START,
  input  logic [XW-1:0] START_X,
  input  logic          FLIP_H,
  input  logic [TW-1:0] TILES,
  output logic          CR_REQ,
  output logic          CR_WSEL,
  input  logic          CR_ACK,
  input  logic [31:0]   CR_IN,
  output logic [31:0]   CR,
  output logic          LOAD,
  output logic          H,
  output logic          EVEN,
  output logic          WR,
  output logic [XW-1:0] WR_X,
  output logic          BUSY,
  output logic          DONE
);

  localparam int CW = TW + 2;

  seq_state_t    state;
  logic [XW-1:0] x;
  logic [CW-1:0] wleft;
  logic [CW-1:0] words_init;
  logic          start_ok;
  logic          buf_full;
  logic          buf_ready;
  logic [31:0]   buf_data;
  logic          pair_ok;

  assign start_ok   = START && (state == IDLE);
  assign words_init = (TILES == '0) ?
                      CW'(WORDS_PER_TILE << TW) :
                      CW'(32'(TILES) * WORDS_PER_TILE);
  assign buf_ready  = buf_full || (CR_REQ && CR_ACK);

`ifdef ZMC2_SEQ_CLIP_EN
  assign pair_ok = 32'(x) < SCREEN_W;
`else
  assign pair_ok = 1'b1;
`endif

  zmc2_word_buf #(
    .CW(CW)
  ) u_buf (
    .clk  (CLK_12M),
    .rst  (RESET),
    .start(start_ok),
    .flip (FLIP_H),
    .words(words_init),
    .ack  (CR_ACK),
    .din  (CR_IN),
    .drain(LOAD),
    .full (buf_full),
    .data (buf_data),
    .req  (CR_REQ),
    .wsel (CR_WSEL)
  );

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      x     <= '0;
      wleft <= '0;
      CR    <= '0;
      LOAD  <= 1'b0;
      H     <= 1'b0;
      EVEN  <= 1'b0;
      WR    <= 1'b0;
      WR_X  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      LOAD <= 1'b0;
      DONE <= 1'b0;
      WR   <= 1'b0;
      // Pair leaves GAD/GBD one cycle after its shift cycle.
      if (is_shift(state)) begin
        WR   <= pair_ok;
        WR_X <= x;
        x    <= x + XW'(2);
      end
      unique case (state)
        IDLE: begin
          if (START) begin
            H     <= FLIP_H;
            EVEN  <= START_X[0];
            x     <= START_X;
            wleft <= words_init;
            BUSY  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (buf_ready) begin
            LOAD  <= 1'b1;
            CR    <= buf_data;
            state <= SHIFT0;
          end
        end
        SHIFT0: begin
          wleft <= wleft - CW'(1);
          state <= SHIFT1;
        end
        SHIFT1: state <= SHIFT2;
        SHIFT2: state <= SHIFT3;
        SHIFT3: begin
          if (wleft == '0) begin
            state <= FLUSH;
          end else if (buf_ready) begin
            LOAD  <= 1'b1;
            CR    <= buf_data;
            state <= SHIFT0;
          end else begin
            state <= WAIT;
          end
        end
        FLUSH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
